// File: rtl/irq_entry_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer: FSM encoding,
// default vector table placement and the vector address helper.
package irq_entry_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_LO = 2'd1,
    PUSH_HI = 2'd2,
    VECTOR  = 2'd3
  } irq_state_e;

  localparam int DEF_VECT_BASE   = 1;
  localparam int DEF_VECT_STRIDE = 1;

  function automatic int vect_addr(int base, int stride, int idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/irq_entry_sequencer.sv
// Interrupt entry sequencer: at an eligible instruction boundary it pushes the
// return PC (low byte first), then loads the vector, clears I and acks the source.
module irq_entry_sequencer
  import irq_entry_sequencer_pkg::*;
#(
  parameter  int NUM_VECTORS = 4,
  parameter  int PC_WIDTH    = 16,
  parameter  int VECT_BASE   = DEF_VECT_BASE,
  parameter  int VECT_STRIDE = DEF_VECT_STRIDE,
  localparam int NVL2        = $clog2(NUM_VECTORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iflag,
  input  logic [NVL2-1:0]     ivect,
  input  logic                gie,
  input  logic                insn_boundary,
  input  logic                reti,
  input  logic [PC_WIDTH-1:0] pc_ret,
  output logic                irq_busy,
  output logic                st_req,
  output logic [7:0]          st_data,
  input  logic                st_ack,
  output logic                pc_load,
  output logic [PC_WIDTH-1:0] pc_new,
  output logic                clr_gie,
  output logic                irq_ack,
  output logic [NVL2-1:0]     ack_vect
);

  irq_state_e          state;
  logic                reti_shadow;
  logic [NVL2-1:0]     vect_q;
  logic [PC_WIDTH-1:0] ret_q;
  logic                take;
  logic [PC_WIDTH-1:0] vec_pc;

  // A boundary coinciding with RETI is never eligible, even before the shadow is set.
  assign take   = (state == IDLE) & iflag & gie & insn_boundary & ~reti_shadow & ~reti;
  assign vec_pc = PC_WIDTH'(vect_addr(VECT_BASE, VECT_STRIDE, int'(vect_q)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      reti_shadow <= 1'b0;
      vect_q      <= '0;
      ret_q       <= '0;
      irq_busy    <= 1'b0;
      st_req      <= 1'b0;
      st_data     <= '0;
      pc_load     <= 1'b0;
      pc_new      <= '0;
      clr_gie     <= 1'b0;
      irq_ack     <= 1'b0;
      ack_vect    <= '0;
    end else begin
      if (reti)               reti_shadow <= 1'b1;
      else if (insn_boundary) reti_shadow <= 1'b0;

      pc_load  <= 1'b0;
      clr_gie  <= 1'b0;
      irq_ack  <= 1'b0;
      pc_new   <= '0;
      ack_vect <= '0;

      // Outputs are registered alongside the state they belong to.
      case (state)
        IDLE: if (take) begin
          vect_q   <= ivect;
          ret_q    <= pc_ret;
          state    <= PUSH_LO;
          irq_busy <= 1'b1;
          st_req   <= 1'b1;
          st_data  <= pc_ret[7:0];
        end
        PUSH_LO: if (st_ack) begin
          state   <= PUSH_HI;
          st_data <= 8'(ret_q >> 8);
        end
        PUSH_HI: if (st_ack) begin
          state    <= VECTOR;
          st_req   <= 1'b0;
          st_data  <= '0;
          pc_load  <= 1'b1;
          clr_gie  <= 1'b1;
          irq_ack  <= 1'b1;
          ack_vect <= vect_q;
          pc_new   <= vec_pc;
        end
        VECTOR: begin
          state    <= IDLE;
          irq_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Bench for irq_entry_sequencer: directed scenarios plus randomized traffic
// checked against a phase-counting reference model.
module tb_irq_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iflag = 1'b0, gie = 1'b0, ib = 1'b0, reti = 1'b0, st_ack = 1'b0;
  logic [1:0]  ivect = '0;
  logic [15:0] pc_ret = '0;

  logic        busy1, req1, load1, clr1, ack1;
  logic [7:0]  data1;
  logic [15:0] pcn1;
  logic [1:0]  av1;
  logic        busy2, req2, load2, clr2, ack2;
  logic [7:0]  data2;
  logic [15:0] pcn2;
  logic [1:0]  av2;

  int ntot = 0;
  int npass = 0;

  // reference model state
  int m_ph = 0;
  bit m_sh = 0;
  int m_v = 0;
  int m_ret = 0;

  always #5 clk = ~clk;

  irq_entry_sequencer dut (
    .clk(clk), .rst(rst), .iflag(iflag), .ivect(ivect), .gie(gie),
    .insn_boundary(ib), .reti(reti), .pc_ret(pc_ret), .irq_busy(busy1),
    .st_req(req1), .st_data(data1), .st_ack(st_ack), .pc_load(load1),
    .pc_new(pcn1), .clr_gie(clr1), .irq_ack(ack1), .ack_vect(av1)
  );

  irq_entry_sequencer #(.VECT_BASE(2), .VECT_STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .iflag(iflag), .ivect(ivect), .gie(gie),
    .insn_boundary(ib), .reti(reti), .pc_ret(pc_ret), .irq_busy(busy2),
    .st_req(req2), .st_data(data2), .st_ack(st_ack), .pc_load(load2),
    .pc_new(pcn2), .clr_gie(clr2), .irq_ack(ack2), .ack_vect(av2)
  );

  wire [30:0] obs  = {busy1, req1, data1, load1, clr1, ack1, av1, pcn1};
  wire [30:0] obs2 = {busy2, req2, data2, load2, clr2, ack2, av2, pcn2};

  function automatic logic [30:0] pk(logic b, logic r, logic [7:0] d, logic v,
                                     logic [1:0] av, logic [15:0] pc);
    return {b, r, d, v, v, v, av, pc};
  endfunction

  // Expected outputs derived from the model phase: 1/2 push bytes, 3 vectors.
  function automatic logic [30:0] mexp(int base, int stride);
    logic [7:0] d;
    d = (m_ph == 1) ? 8'(m_ret) : (m_ph == 2) ? 8'(m_ret / 256) : 8'd0;
    return pk(m_ph != 0, m_ph == 1 || m_ph == 2, d, m_ph == 3,
              (m_ph == 3) ? 2'(m_v) : 2'd0,
              (m_ph == 3) ? 16'(base + m_v * stride) : 16'd0);
  endfunction

  task automatic tick();
    bit tk;
    if (rst) begin
      m_ph = 0; m_sh = 0; m_v = 0; m_ret = 0;
    end else begin
      tk = (m_ph == 0) && iflag && gie && ib && !m_sh && !reti;
      m_sh = reti ? 1'b1 : (ib ? 1'b0 : m_sh);
      if (m_ph == 0) begin
        if (tk) begin m_v = int'(ivect); m_ret = int'(pc_ret); m_ph = 1; end
      end else if (m_ph == 3) m_ph = 0;
      else if (st_ack) m_ph = m_ph + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic settle();
    rst = 0; iflag = 0; gie = 0; reti = 0; ib = 1; st_ack = 1;
    repeat (5) tick();
    ib = 0;
  endtask

  task automatic take_now(input logic [1:0] v, input logic [15:0] pc);
    iflag = 1; gie = 1; ib = 1; reti = 0; ivect = v; pc_ret = pc;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    ntot++; if (obs !== 31'd0) $display("FAIL reset got=%h exp=0", obs); else npass++;
    ntot++; if (obs2 !== 31'd0) $display("FAIL reset2 got=%h exp=0", obs2); else npass++;
  endtask

  task automatic test_basic();
    settle();
    take_now(2'd2, 16'h1234); st_ack = 1;
    tick(); iflag = 0; ib = 0;
    ntot++; if (obs !== pk(1,1,8'h34,0,0,0)) $display("FAIL basic_lo got=%h exp=%h", obs, pk(1,1,8'h34,0,0,0)); else npass++;
    tick();
    ntot++; if (obs !== pk(1,1,8'h12,0,0,0)) $display("FAIL basic_hi got=%h exp=%h", obs, pk(1,1,8'h12,0,0,0)); else npass++;
    tick();
    ntot++; if (obs !== pk(1,0,0,1,2,3)) $display("FAIL basic_vec got=%h exp=%h", obs, pk(1,0,0,1,2,3)); else npass++;
    ntot++; if (obs2 !== pk(1,0,0,1,2,6)) $display("FAIL basic_vec2 got=%h exp=%h", obs2, pk(1,0,0,1,2,6)); else npass++;
    tick();
    ntot++; if (obs !== 31'd0) $display("FAIL basic_idle got=%h exp=0", obs); else npass++;
  endtask

  task automatic test_stall();
    settle();
    take_now(2'd3, 16'h5a6b); st_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); iflag = 0; ib = 0;
      ntot++; if (obs !== pk(1,1,8'h6b,0,0,0)) $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, pk(1,1,8'h6b,0,0,0)); else npass++;
    end
    st_ack = 1;
    tick();
    ntot++; if (obs !== pk(1,1,8'h5a,0,0,0)) $display("FAIL stall_hi got=%h exp=%h", obs, pk(1,1,8'h5a,0,0,0)); else npass++;
    tick();
    ntot++; if (obs !== pk(1,0,0,1,3,4)) $display("FAIL stall_vec got=%h exp=%h", obs, pk(1,0,0,1,3,4)); else npass++;
    ntot++; if (obs2 !== pk(1,0,0,1,3,8)) $display("FAIL stride_vec got=%h exp=%h", obs2, pk(1,0,0,1,3,8)); else npass++;
    tick();
  endtask

  task automatic test_gie();
    settle();
    take_now(2'd1, 16'h00c3); gie = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ntot++; if (obs !== 31'd0) $display("FAIL gie_off%0d got=%h exp=0", i, obs); else npass++;
    end
    gie = 1; ib = 0;
    tick();
    ntot++; if (obs !== 31'd0) $display("FAIL gie_noboundary got=%h exp=0", obs); else npass++;
    ib = 1;
    tick();
    ntot++; if (obs !== pk(1,1,8'hc3,0,0,0)) $display("FAIL gie_take got=%h exp=%h", obs, pk(1,1,8'hc3,0,0,0)); else npass++;
  endtask

  task automatic test_reti();
    settle();
    take_now(2'd0, 16'h0777); reti = 1;
    tick(); reti = 0;
    ntot++; if (obs !== 31'd0) $display("FAIL reti_t got=%h exp=0", obs); else npass++;
    tick();
    ntot++; if (obs !== 31'd0) $display("FAIL reti_t1 got=%h exp=0", obs); else npass++;
    tick();
    ntot++; if (obs !== pk(1,1,8'h77,0,0,0)) $display("FAIL reti_t2 got=%h exp=%h", obs, pk(1,1,8'h77,0,0,0)); else npass++;
  endtask

  task automatic test_withdraw();
    settle();
    take_now(2'd1, 16'h0abc);
    tick(); iflag = 0; ivect = 0; pc_ret = 0; gie = 0; ib = 1;
    ntot++; if (obs !== pk(1,1,8'hbc,0,0,0)) $display("FAIL wd_lo got=%h exp=%h", obs, pk(1,1,8'hbc,0,0,0)); else npass++;
    tick();
    ntot++; if (obs !== pk(1,1,8'h0a,0,0,0)) $display("FAIL wd_hi got=%h exp=%h", obs, pk(1,1,8'h0a,0,0,0)); else npass++;
    tick();
    ntot++; if (obs !== pk(1,0,0,1,1,2)) $display("FAIL wd_vec got=%h exp=%h", obs, pk(1,0,0,1,1,2)); else npass++;
    tick();
  endtask

  task automatic test_rst_mid();
    settle();
    take_now(2'd2, 16'h4321);
    tick(); ib = 0;
    tick();
    ntot++; if (obs !== pk(1,1,8'h43,0,0,0)) $display("FAIL rst_pre got=%h exp=%h", obs, pk(1,1,8'h43,0,0,0)); else npass++;
    rst = 1;
    tick(); rst = 0;
    ntot++; if (obs !== 31'd0) $display("FAIL rst_mid got=%h exp=0", obs); else npass++;
    ntot++; if (obs2 !== 31'd0) $display("FAIL rst_mid2 got=%h exp=0", obs2); else npass++;
    ib = 1;
    tick();
    ntot++; if (obs !== pk(1,1,8'h21,0,0,0)) $display("FAIL rst_restart got=%h exp=%h", obs, pk(1,1,8'h21,0,0,0)); else npass++;
  endtask

  task automatic test_random();
    settle();
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      iflag  = $urandom_range(0, 1);
      gie    = ($urandom_range(0, 3) != 0);
      ib     = $urandom_range(0, 1);
      reti   = ($urandom_range(0, 7) == 0);
      st_ack = ($urandom_range(0, 3) != 0);
      ivect  = 2'($urandom_range(0, 3));
      pc_ret = 16'($urandom);
      tick();
      ntot++; if (obs !== mexp(1, 1)) $display("FAIL rand%0d got=%h exp=%h", i, obs, mexp(1, 1)); else npass++;
      ntot++; if (obs2 !== mexp(2, 2)) $display("FAIL rand2_%0d got=%h exp=%h", i, obs2, mexp(2, 2)); else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gie();
    test_reti();
    test_withdraw();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
